// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES constants, FSM state encoding and the forward S-box
//            table. The key-expansion block uses the same table.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

   localparam int BLOCK_W = 128;
   localparam int BYTE_W  = 8;
   localparam int NBYTES  = BLOCK_W / BYTE_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // FIPS-197 forward S-box, entry 0 in the most significant byte
   localparam logic [0:255][BYTE_W-1:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

endpackage : aes_pkg
`default_nettype wire

// File: rtl/sub_bytes_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_iter_if
// Purpose  : Input and output valid/ready channels of the SubBytes unit.
//            slave = unit side, master = producer/consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface sub_bytes_iter_if;
   import aes_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [BLOCK_W-1:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] out_data;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

endinterface : sub_bytes_iter_if
`default_nettype wire

// File: rtl/sbox_lane.sv
`default_nettype none
// ============================================================================
// Module   : sbox_lane
// Purpose  : One forward S-box: combinational byte lookup in the shared table.
// Revision : 1.0 - initial release
// ============================================================================
module sbox_lane
   import aes_pkg::*;
(
   input  wire logic [BYTE_W-1:0] i_byte,
   output logic      [BYTE_W-1:0] o_byte
);

   assign o_byte = SBOX[i_byte];

endmodule : sbox_lane
`default_nettype wire

// File: rtl/sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_iter
// Purpose  : Iterative forward AES SubBytes. LANES S-boxes are swept across
//            the 16-byte state, low bytes first, over 16/LANES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module sub_bytes_iter
   import aes_pkg::*;
#(
   parameter int LANES = 4
)(
   input  wire logic        clk,
   input  wire logic        rst_n,
   sub_bytes_iter_if.slave  bus
);

   localparam int NPASS = NBYTES / LANES;
   localparam int CNT_W = (NPASS > 1) ? $clog2(NPASS) : 1;

   state_t                           r_st;
   state_t                           w_st_nxt;
   logic [CNT_W-1:0]                 r_cnt;
   logic [NBYTES-1:0][BYTE_W-1:0]    r_buf;
   logic [NBYTES-1:0][BYTE_W-1:0]    w_buf_nxt;

   logic                             w_in_ready;
   logic                             w_out_valid;
   logic                             w_load;
   logic                             w_pass;
   logic                             w_last;

   // Base byte of the current pass; 5 bits so LANES*cnt never overflows
   logic [4:0]                       w_base;
   logic [3:0]                       w_idx      [LANES];
   logic [BYTE_W-1:0]                w_lane_in  [LANES];
   logic [BYTE_W-1:0]                w_lane_out [LANES];

   assign w_last = (r_cnt == CNT_W'(NPASS - 1));
   assign w_base = 5'(LANES) * 5'(r_cnt);

   // Lane mux: lane g always sees byte (base + g) of the working buffer
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_idx[g]     = 4'(w_base + 5'(g));
      assign w_lane_in[g] = r_buf[w_idx[g]];

      sbox_lane u_sbox (
         .i_byte (w_lane_in[g]),
         .o_byte (w_lane_out[g])
      );
   end

   // Lane demux: substituted bytes are written back in place
   always_comb begin
      w_buf_nxt = r_buf;
      for (int l = 0; l < LANES; l++) begin
         w_buf_nxt[w_idx[l]] = w_lane_out[l];
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_st <= IDLE;
      end else begin
         r_st <= w_st_nxt;
      end
   end

   // Next state and handshake outputs; no overlapped accept while DONE
   always_comb begin
      w_st_nxt    = r_st;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_load      = 1'b0;
      w_pass      = 1'b0;
      case (r_st)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_load   = 1'b1;
               w_st_nxt = BUSY;
            end
         end
         BUSY: begin
            w_pass = 1'b1;
            if (w_last) begin
               w_st_nxt = DONE;
            end
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_st_nxt = IDLE;
            end
         end
         default: begin
            w_st_nxt = IDLE;
         end
      endcase
   end

   // Working buffer and pass counter; counter wraps to 0 on the last pass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_buf <= '0;
      end else if (w_load) begin
         r_cnt <= '0;
         r_buf <= bus.in_data;
      end else if (w_pass) begin
         r_buf <= w_buf_nxt;
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = r_buf;

endmodule : sub_bytes_iter
`default_nettype wire

// File: tb/tb_sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_bytes_iter
// Purpose  : Scoreboard bench for sub_bytes_iter with LANES = 4, 8 and 16
//            driven by one shared stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_iter;

   logic         clk;
   logic         rst_n;
   logic         tb_iv;
   logic [127:0] tb_id;
   logic         tb_ordy;

   int n_vec;
   int n_err;
   int cyc;

   sub_bytes_iter_if u_if4 ();
   sub_bytes_iter_if u_if8 ();
   sub_bytes_iter_if u_if16 ();

   assign u_if4.in_valid   = tb_iv;
   assign u_if4.in_data    = tb_id;
   assign u_if4.out_ready  = tb_ordy;
   assign u_if8.in_valid   = tb_iv;
   assign u_if8.in_data    = tb_id;
   assign u_if8.out_ready  = tb_ordy;
   assign u_if16.in_valid  = tb_iv;
   assign u_if16.in_data   = tb_id;
   assign u_if16.out_ready = tb_ordy;

   sub_bytes_iter #(.LANES(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(u_if4.slave));
   sub_bytes_iter #(.LANES(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(u_if8.slave));
   sub_bytes_iter #(.LANES(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(u_if16.slave));

   wire         w_ov [3];
   wire         w_ir [3];
   wire [127:0] w_od [3];
   assign w_ov[0] = u_if4.out_valid;  assign w_ir[0] = u_if4.in_ready;  assign w_od[0] = u_if4.out_data;
   assign w_ov[1] = u_if8.out_valid;  assign w_ir[1] = u_if8.in_ready;  assign w_od[1] = u_if8.out_data;
   assign w_ov[2] = u_if16.out_valid; assign w_ir[2] = u_if16.in_ready; assign w_od[2] = u_if16.out_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model (GF(2^8) inverse + affine map) -------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] v);
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      if (v != 8'h00) begin
         for (int y = 1; y < 256; y++) begin
            if (gmul(v, 8'(y)) == 8'h01) inv = 8'(y);
         end
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      return s;
   endfunction

   function automatic logic [127:0] sub_ref(input logic [127:0] d);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_ref(d[8*k +: 8]);
      return r;
   endfunction

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic [127:0] exp_q  [3][$];
   int           acc_q  [3][$];
   logic         prev_ov [3];
   logic [127:0] last_out [3];
   int           n_out  [3];
   int           npass  [3] = '{4, 2, 1};
   string        nm     [3] = '{"L4", "L8", "L16"};

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (!rst_n) begin
            exp_q[d].delete();
            acc_q[d].delete();
            prev_ov[d] = 1'b0;
         end else begin
            if (w_ov[d]) begin
               chk({nm[d], "_inrdy_in_done"}, 128'(w_ir[d]), 128'd0);
               if (exp_q[d].size() == 0) begin
                  chk({nm[d], "_unexpected_out"}, 128'(w_ov[d]), 128'd0);
               end else begin
                  if (!prev_ov[d]) begin
                     chk({nm[d], "_latency"}, 128'(cyc), 128'(acc_q[d][0] + npass[d]));
                  end
                  chk({nm[d], "_data"}, w_od[d], exp_q[d][0]);
                  if (tb_ordy) begin
                     last_out[d] = w_od[d];
                     n_out[d]++;
                     void'(exp_q[d].pop_front());
                     void'(acc_q[d].pop_front());
                  end
               end
            end
            if (tb_iv && w_ir[d]) begin
               exp_q[d].push_back(sub_ref(tb_id));
               acc_q[d].push_back(cyc + 1);
            end
            prev_ov[d] = w_ov[d];
         end
      end
   end

   // ---------------- stimulus helpers (called at posedge + 1) -----------
   task automatic send(input logic [127:0] d);
      int t = 0;
      while (!u_if4.in_ready && t < 100) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 100) chk("send_timeout", 128'd0, 128'd1);
      tb_iv = 1'b1;
      tb_id = d;
      @(posedge clk); #1;
      tb_iv = 1'b0;
   endtask

   task automatic wait_out();
      int t  = 0;
      int n0 = n_out[0];
      while (n_out[0] == n0 && t < 100) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 100) chk("out_timeout", 128'd0, 128'd1);
   endtask

   task automatic wait_valid();
      int t = 0;
      while (!u_if4.out_valid && t < 100) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 100) chk("valid_timeout", 128'd0, 128'd1);
   endtask

   localparam logic [127:0] C_ZERO_OUT = {16{8'h63}};
   localparam logic [127:0] C_FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] C_FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] C_EDGE_IN  = 128'hffeeddccbbaa99887766554433221100;

   initial begin
      logic [127:0] blk;
      int           n0;
      n_vec = 0; n_err = 0; cyc = 0;
      for (int d = 0; d < 3; d++) begin
         n_out[d] = 0; last_out[d] = '0; prev_ov[d] = 1'b0;
      end
      tb_iv = 1'b0; tb_id = '0; tb_ordy = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;

      // Reset state, held for 10 idle cycles
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) begin
            chk({nm[d], "_rst_inrdy"}, 128'(w_ir[d]), 128'd1);
            chk({nm[d], "_rst_ovalid"}, 128'(w_ov[d]), 128'd0);
            chk({nm[d], "_rst_odata"}, w_od[d], 128'd0);
         end
      end

      // All-zero block: 0x63 everywhere, in_ready back one cycle after out_valid
      send(128'd0);
      wait_valid();
      @(posedge clk); #1;
      chk("zero_inrdy_back", 128'(u_if4.in_ready), 128'd1);
      chk("zero_ovalid_drop", 128'(u_if4.out_valid), 128'd0);
      for (int d = 0; d < 3; d++) chk({nm[d], "_zero_out"}, last_out[d], C_ZERO_OUT);

      // FIPS-197 Appendix B round 1
      send(C_FIPS_IN);
      wait_out();
      for (int d = 0; d < 3; d++) chk({nm[d], "_fips_out"}, last_out[d], C_FIPS_OUT);

      // Backpressure in DONE with a new block waiting on the input
      tb_ordy = 1'b0;
      send(C_EDGE_IN);
      wait_valid();
      blk   = {$urandom, $urandom, $urandom, $urandom};
      tb_iv = 1'b1;
      tb_id = blk;
      repeat (20) begin
         @(posedge clk); #1;
      end
      chk("bp_ovalid_held", 128'(u_if4.out_valid), 128'd1);
      chk("bp_inrdy_held", 128'(u_if4.in_ready), 128'd0);
      n0 = n_out[0];
      tb_ordy = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tb_iv = 1'b0;
      chk("bp_one_transfer", 128'(n_out[0]), 128'(n0 + 1));
      chk("edge_byte0", 128'(last_out[0][7:0]), 128'h63);
      chk("edge_byte15", 128'(last_out[0][127:120]), 128'h16);
      chk("edge_byte5", 128'(last_out[0][47:40]), 128'hfc);
      chk("edge_model", last_out[0], sub_ref(C_EDGE_IN));
      wait_out();

      // Random blocks
      repeat (5) begin
         send({$urandom, $urandom, $urandom, $urandom});
         wait_out();
      end

      // Reset in the second BUSY cycle aborts the block
      n0 = n_out[0];
      send({$urandom, $urandom, $urandom, $urandom});
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_inrdy", 128'(u_if4.in_ready), 128'd1);
      chk("abort_ovalid", 128'(u_if4.out_valid), 128'd0);
      chk("abort_odata", u_if4.out_data, 128'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (6) begin
         @(posedge clk); #1;
      end
      chk("abort_no_output", 128'(n_out[0]), 128'(n0));
      blk = {$urandom, $urandom, $urandom, $urandom};
      send(blk);
      wait_out();
      chk("post_abort_out", last_out[0], sub_ref(blk));

      repeat (4) @(posedge clk);
      for (int d = 0; d < 3; d++) chk({nm[d], "_drain"}, 128'(exp_q[d].size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_sub_bytes_iter
`default_nettype wire
